// File: rtl/axi_buffer_ch_if.sv
// AXI4 bus bundle with master/slave views.
// Shared by the buffer and its neighbours.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6
);
  localparam int unsigned SW = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [3:0]                aw_qos;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]             w_strb;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_last;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [3:0]                ar_qos;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst,
    output aw_lock, aw_cache, aw_qos, aw_id, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_user, w_last, w_valid,
    input  w_ready,
    input  b_resp, b_id, b_user, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst,
    output ar_lock, ar_cache, ar_qos, ar_id, ar_user, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_last, r_id, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_region, aw_len, aw_size, aw_burst,
    input  aw_lock, aw_cache, aw_qos, aw_id, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_user, w_last, w_valid,
    output w_ready,
    output b_resp, b_id, b_user, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_region, ar_len, ar_size, ar_burst,
    input  ar_lock, ar_cache, ar_qos, ar_id, ar_user, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_last, r_id, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_buffer_ch.sv
// Five-channel AXI4 buffer, one registered-output FIFO per channel.
// AXI_BUFFER_OCCUPANCY_EN adds occupancy and overflow-attempt outputs.
module axi_buffer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [WIDTH-1:0]        in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o
`ifdef AXI_BUFFER_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0]  cnt_o
`endif
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_buffer_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = !rst_i && (cnt_q != FULL);
  assign out_valid_o = !rst_i && (cnt_q != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign out_data_o  = data_q;
`ifdef AXI_BUFFER_OCCUPANCY_EN
  assign cnt_o = rst_i ? '0 : cnt_q;
`endif

  // data_q always holds the head; it only changes when the head moves
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    data_d = data_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && (cnt_q == CW'(pop))) begin
      data_d = in_data_i;
    end else if (pop && (cnt_q > CW'(1))) begin
      data_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    if (push) mem_q[wptr_q] <= in_data_i;
  end
endmodule

module axi_buffer_ch #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 10,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned AW_DEPTH       = 2,
  parameter int unsigned W_DEPTH        = 4,
  parameter int unsigned B_DEPTH        = 2,
  parameter int unsigned AR_DEPTH       = 2,
  parameter int unsigned R_DEPTH        = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  AXI_BUS.Slave                      slv,
  AXI_BUS.Master                     mst
`ifdef AXI_BUFFER_OCCUPANCY_EN
  ,
  output logic [$clog2(AW_DEPTH):0]  aw_occ_o,
  output logic [$clog2(W_DEPTH):0]   w_occ_o,
  output logic [$clog2(B_DEPTH):0]   b_occ_o,
  output logic [$clog2(AR_DEPTH):0]  ar_occ_o,
  output logic [$clog2(R_DEPTH):0]   r_occ_o,
  output logic                       overflow_attempt_o
`endif
);
  localparam int unsigned A  = AXI_ADDR_WIDTH;
  localparam int unsigned D  = AXI_DATA_WIDTH;
  localparam int unsigned I  = AXI_ID_WIDTH;
  localparam int unsigned U  = AXI_USER_WIDTH;
  localparam int unsigned AXW = A + 29 + I + U;
  localparam int unsigned WW  = D + D / 8 + U + 1;
  localparam int unsigned BW  = 2 + I + U;
  localparam int unsigned RW  = D + 3 + I + U;

  logic [AXW-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [WW-1:0]  w_in, w_out;
  logic [BW-1:0]  b_in, b_out;
  logic [RW-1:0]  r_in, r_out;

  assign aw_in = {slv.aw_addr, slv.aw_prot, slv.aw_region, slv.aw_len,
                  slv.aw_size, slv.aw_burst, slv.aw_lock, slv.aw_cache,
                  slv.aw_qos, slv.aw_id, slv.aw_user};
  assign {mst.aw_addr, mst.aw_prot, mst.aw_region, mst.aw_len,
          mst.aw_size, mst.aw_burst, mst.aw_lock, mst.aw_cache,
          mst.aw_qos, mst.aw_id, mst.aw_user} = aw_out;

  assign ar_in = {slv.ar_addr, slv.ar_prot, slv.ar_region, slv.ar_len,
                  slv.ar_size, slv.ar_burst, slv.ar_lock, slv.ar_cache,
                  slv.ar_qos, slv.ar_id, slv.ar_user};
  assign {mst.ar_addr, mst.ar_prot, mst.ar_region, mst.ar_len,
          mst.ar_size, mst.ar_burst, mst.ar_lock, mst.ar_cache,
          mst.ar_qos, mst.ar_id, mst.ar_user} = ar_out;

  assign w_in = {slv.w_data, slv.w_strb, slv.w_user, slv.w_last};
  assign {mst.w_data, mst.w_strb, mst.w_user, mst.w_last} = w_out;

  assign b_in = {mst.b_resp, mst.b_id, mst.b_user};
  assign {slv.b_resp, slv.b_id, slv.b_user} = b_out;

  assign r_in = {mst.r_data, mst.r_resp, mst.r_last, mst.r_id, mst.r_user};
  assign {slv.r_data, slv.r_resp, slv.r_last, slv.r_id, slv.r_user} = r_out;

  axi_buffer_fifo #(.WIDTH(AXW), .DEPTH(AW_DEPTH)) u_aw (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(slv.aw_valid), .in_ready_o(slv.aw_ready), .in_data_i(aw_in),
    .out_valid_o(mst.aw_valid), .out_ready_i(mst.aw_ready), .out_data_o(aw_out)
`ifdef AXI_BUFFER_OCCUPANCY_EN
    , .cnt_o(aw_occ_o)
`endif
  );

  axi_buffer_fifo #(.WIDTH(WW), .DEPTH(W_DEPTH)) u_w (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(slv.w_valid), .in_ready_o(slv.w_ready), .in_data_i(w_in),
    .out_valid_o(mst.w_valid), .out_ready_i(mst.w_ready), .out_data_o(w_out)
`ifdef AXI_BUFFER_OCCUPANCY_EN
    , .cnt_o(w_occ_o)
`endif
  );

  axi_buffer_fifo #(.WIDTH(BW), .DEPTH(B_DEPTH)) u_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(mst.b_valid), .in_ready_o(mst.b_ready), .in_data_i(b_in),
    .out_valid_o(slv.b_valid), .out_ready_i(slv.b_ready), .out_data_o(b_out)
`ifdef AXI_BUFFER_OCCUPANCY_EN
    , .cnt_o(b_occ_o)
`endif
  );

  axi_buffer_fifo #(.WIDTH(AXW), .DEPTH(AR_DEPTH)) u_ar (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(slv.ar_valid), .in_ready_o(slv.ar_ready), .in_data_i(ar_in),
    .out_valid_o(mst.ar_valid), .out_ready_i(mst.ar_ready), .out_data_o(ar_out)
`ifdef AXI_BUFFER_OCCUPANCY_EN
    , .cnt_o(ar_occ_o)
`endif
  );

  axi_buffer_fifo #(.WIDTH(RW), .DEPTH(R_DEPTH)) u_r (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(mst.r_valid), .in_ready_o(mst.r_ready), .in_data_i(r_in),
    .out_valid_o(slv.r_valid), .out_ready_i(slv.r_ready), .out_data_o(r_out)
`ifdef AXI_BUFFER_OCCUPANCY_EN
    , .cnt_o(r_occ_o)
`endif
  );

`ifdef AXI_BUFFER_OCCUPANCY_EN
  // outside reset, ready is low only when the FIFO is full
  assign overflow_attempt_o = !rst_i && (
    (slv.aw_valid && !slv.aw_ready) ||
    (slv.w_valid  && !slv.w_ready)  ||
    (slv.ar_valid && !slv.ar_ready) ||
    (mst.b_valid  && !mst.b_ready)  ||
    (mst.r_valid  && !mst.r_ready));
`endif
endmodule
